// File: rtl/fulladd_pkg.sv
// Shared constants and types for the ripple-carry full adder.
// Holds the default width and the one-bit sum/carry result bundle.
package fulladd_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;

  typedef struct packed {
    logic s;
    logic c;
  } fa_bit_t;

endpackage

// File: rtl/fulladd_behavioral_fa_cell.sv
// One-bit full adder cell used as a ripple-chain stage.
// Produces the sum bit and the carry into the next stage.
module fa_cell
  import fulladd_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    ci,
  output fa_bit_t res
);

  logic p;

  // Propagate term is shared by sum and carry.
  always_comb begin
    p     = a ^ b;
    res.s = p ^ ci;
    res.c = (a & b) | (ci & p);
  end

endmodule

// File: rtl/fulladd_behavioral.sv
// Registered ripple-carry adder: {cout,s} = a + b + cin, one cycle latency.
// Define FULLADD_XCHECK_EN to add behavioral and gate-primitive cross-checks.
module fulladd_behavioral
  import fulladd_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid,
  output logic             xcheck_err
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_w;
  fa_bit_t          r [WIDTH];

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rip
    fa_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .res(r[i])
    );
    assign sum_w[i] = r[i].s;
    assign c[i+1]   = r[i].c;
  end

  // Result register; holds on idle cycles, valid pulses per input.
  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum_w;
        cout <= c[WIDTH];
      end
    end
  end

`ifdef FULLADD_XCHECK_EN
  logic [WIDTH:0] beh_sum;
  logic [WIDTH:0] gate_sum;
  logic [WIDTH:0] gc;

  assign beh_sum = {1'b0, a} + {1'b0, b}
                 + {{WIDTH{1'b0}}, cin};
  assign gc[0]   = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_gate
    wire t;
    wire p;
    wire q;
    xor x0 (t, a[i], b[i]);
    xor x1 (gate_sum[i], t, gc[i]);
    and n0 (p, a[i], b[i]);
    and n1 (q, gc[i], t);
    or  o0 (gc[i+1], p, q);
  end

  assign gate_sum[WIDTH] = gc[WIDTH];

  // Sticky flag: any disagreement between the three styles.
  always_ff @(posedge clk) begin
    if (rst) begin
      xcheck_err <= 1'b0;
    end else if (in_valid) begin
      if ((beh_sum != {c[WIDTH], sum_w}) ||
          (gate_sum != {c[WIDTH], sum_w}))
        xcheck_err <= 1'b1;
    end
  end
`else
  assign xcheck_err = 1'b0;
`endif

endmodule

// File: tb/tb_fulladd_behavioral.sv
// Scoreboard bench for fulladd_behavioral at WIDTH=1 and WIDTH=4.
// Expected sums come from plain integer arithmetic.
module tb_fulladd_behavioral;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       in_valid;

  logic [3:0] s4;
  logic       cout4, ov4, xe4;
  logic [0:0] s1;
  logic       cout1, ov1, xe1;

  int total = 0;
  int bad   = 0;

  logic [4:0] q4 [$];
  logic [1:0] q1 [$];

  always #5 clk = ~clk;

  fulladd_behavioral #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
    .in_valid(in_valid), .s(s4), .cout(cout4),
    .out_valid(ov4), .xcheck_err(xe4)
  );

  fulladd_behavioral #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .a(a[0]), .b(b[0]), .cin(cin),
    .in_valid(in_valid), .s(s1), .cout(cout1),
    .out_valid(ov1), .xcheck_err(xe1)
  );

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Monitor for the 4-bit instance.
  always @(posedge clk) begin
    #1;
    if (ov4 === 1'b1) begin
      if (q4.size() == 0) chk("w4_spurious_valid", 1, 0);
      else chk("w4_sum", {cout4, s4}, q4.pop_front());
    end
  end

  // Monitor for the 1-bit instance.
  always @(posedge clk) begin
    #1;
    if (ov1 === 1'b1) begin
      if (q1.size() == 0) chk("w1_spurious_valid", 1, 0);
      else chk("w1_sum", {cout1, s1}, q1.pop_front());
    end
  end

  task automatic step(input logic [3:0] ta, input logic [3:0] tb_,
                      input logic tc, input logic tv);
    int e4, e1;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; in_valid = tv;
    if (tv && !rst) begin
      e4 = int'(ta) + int'(tb_) + int'(tc);
      e1 = int'(ta[0]) + int'(tb_[0]) + int'(tc);
      q4.push_back(e4[4:0]);
      q1.push_back(e1[1:0]);
    end
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_s4", {cout4, s4}, 0);
    chk("rst_ov4", ov4, 0);
    chk("rst_s1", {cout1, s1}, 0);
    chk("rst_ov1", ov1, 0);
    chk("rst_xe4", xe4, 0);
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive 3-bit {a,b,cin} walk, back to back.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      step({3'b0, v[2]}, {3'b0, v[1]}, v[0], 1'b1);
    end

    step(4'hF, 4'h1, 1'b0, 1'b1);
    step(4'h5, 4'hA, 1'b1, 1'b1);
    step(4'hF, 4'hF, 1'b1, 1'b1);

    // Hold: three idle cycles keep the last result.
    step(4'h3, 4'h4, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
      @(posedge clk);
      #2;
      chk("hold_s4", {cout4, s4}, 7);
      chk("hold_ov4", ov4, 0);
      chk("hold_ov1", ov1, 0);
    end

    // Random traffic with random gaps.
    for (int i = 0; i < 200; i++)
      step(4'($urandom), 4'($urandom), 1'($urandom),
           1'($urandom_range(0, 3) != 0));
    step(4'h0, 4'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("xe_clean4", xe4, 0);
    chk("xe_clean1", xe1, 0);

    // Reset wins over a same-cycle operand.
    @(negedge clk);
    rst = 1'b1; a = 4'h1; b = 4'h1; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #2;
    chk("rstpri_s4", {cout4, s4}, 0);
    chk("rstpri_ov4", ov4, 0);
    chk("rstpri_s1", {cout1, s1}, 0);
    chk("rstpri_ov1", ov1, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;

    // First operand after reset is correct.
    step(4'h9, 4'h8, 1'b1, 1'b1);
    step(4'h0, 4'h0, 1'b0, 1'b0);

`ifdef FULLADD_XCHECK_EN
    @(negedge clk);
    force u1.beh_sum = 2'b11;
    step(4'h0, 4'h0, 1'b0, 1'b1);
    step(4'h0, 4'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    release u1.beh_sum;
    chk("xe_set1", xe1, 1);
    step(4'h0, 4'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("xe_sticky1", xe1, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("xe_clr1", xe1, 0);
    @(negedge clk);
    rst = 1'b0;
`endif

    repeat (4) @(posedge clk);
    #2;
    chk("q4_drained", q4.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fulladd_behavioral.md
FULLADD_BEHAVIORAL -- requirements
Module: fulladd_behavioral

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 1: operand width in bits; WIDTH=1 is a single full adder.
Ports (name  direction  width  meaning):
REQ-002 The block SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port a  input  WIDTH  addend A.
REQ-005 The block SHALL have port b  input  WIDTH  addend B.
REQ-006 The block SHALL have port cin  input  1  carry-in.
REQ-007 The block SHALL have port in_valid  input  1  qualifies a, b and cin in the current cycle.
REQ-008 The block SHALL have port s  output  WIDTH  registered sum.
REQ-009 The block SHALL have port cout  output  1  registered carry-out.
REQ-010 The block SHALL have port out_valid  output  1  s and cout hold a new result.
REQ-011 The block SHALL have port xcheck_err  output  1  sticky flag for cross-check mismatch.

Function
REQ-012 {cout, s} SHALL equal the zero-extended sum a + b + cin, computed at WIDTH+1 bits with no truncation of the carry.
REQ-013 The datapath SHALL be a ripple chain of WIDTH one-bit cells: carry into bit 0 is cin; carry out of bit i feeds bit i+1; cout is the carry out of bit WIDTH-1.
REQ-014 Each one-bit cell SHALL compute s_i = a_i ^ b_i ^ c_i and c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)).
REQ-015 Latency SHALL be exactly 1 cycle: a rising edge with in_valid=1 loads s and cout and sets out_valid=1 in the same edge.
REQ-016 On a rising edge with in_valid=0, s and cout SHALL hold their previous values and out_valid SHALL be 0.
REQ-017 Back-to-back in_valid=1 cycles SHALL each produce a result; there is no backpressure and no stall.
REQ-018 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-019 While rst=1 at a rising edge, s, cout, out_valid and xcheck_err SHALL all become 0.
REQ-020 rst SHALL take priority over in_valid; an operand presented in the same cycle as rst is discarded.
REQ-021 After rst is released, the first in_valid=1 edge SHALL produce a correct result with no warm-up cycles.

Configuration
REQ-022 With macro FULLADD_XCHECK_EN defined, the block SHALL also compute the sum in two further styles: a behavioral a+b+cin expression and gate-primitive cells (xor, and, or).
REQ-023 With FULLADD_XCHECK_EN defined, on every in_valid=1 edge xcheck_err SHALL be set if the results of the three styles differ; it stays set until reset.
REQ-024 Without FULLADD_XCHECK_EN, the extra logic SHALL be absent and xcheck_err SHALL be constant 0.

Structure
REQ-025 Package fulladd_pkg SHALL hold the constant FA_DEFAULT_WIDTH = 1 and the sum/carry result struct typedef.
REQ-026 Sub-module fa_cell SHALL implement the one-bit full adder of REQ-014 and SHALL be instantiated WIDTH times by a generate loop.

Verification
REQ-027 With WIDTH=1, drive {a,b,cin} = 0..7 (one per cycle, in_valid=1) -> {cout,s} one cycle later SHALL be 00,01,01,10,01,10,10,11.
REQ-028 With WIDTH=4, a=4'hF, b=4'h1, cin=0 -> s=4'h0, cout=1; a=4'h5, b=4'hA, cin=1 -> s=4'h0, cout=1.
REQ-029 Apply a valid operand, then hold in_valid=0 for 3 cycles -> s and cout SHALL be unchanged and out_valid SHALL be 0.
REQ-030 Assert rst in the same cycle as in_valid=1 with a=1, b=1 -> s=0, cout=0, out_valid=0 on the next edge.
REQ-031 With FULLADD_XCHECK_EN defined, run exhaustive WIDTH=1 stimulus -> xcheck_err SHALL stay 0; force a mismatch in one style -> xcheck_err=1 until rst.
